hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the RV32I 5-stage core. It watches the register addresses leaving Decode, the load/branch state of EX, and the data-memory busy line. From these it drives the Decode stage's `stall`/`flush` inputs and the per-stage pipeline-register write enables. It sequences load-use bubbles, taken-branch flushes and memory-wait freezes, and keeps cycle counters for performance analysis.

## Interface
- `LOAD_USE_CYCLES`, default 1: bubbles inserted per load-use hazard (1..7).
- `FLUSH_CYCLES`, default 1: cycles `flush` is held per taken branch (1..7).
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset: synchronous and active-high.
- `id_rs1`  in  5  rs1 address from Decode; 0 when the instruction has no rs1.
- `id_rs2`  in  5  rs2 address from Decode; 0 when the instruction has no rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_memread`  in  1  the instruction in EX is a load.
- `branch_taken`  in  1  EX resolved a taken branch/JAL/JALR this cycle.
- `dmem_busy`  in  1  data memory cannot complete this cycle.
- `pc_write`  out  1  PC register enable.
- `ifid_write`  out  1  IF/ID register enable.
- `idex_write`  out  1  ID/EX register enable.
- `exmem_write`  out  1  EX/MEM and MEM/WB register enable.
- `stall`  out  1  to Decode; forces its control outputs to zero.
- `flush`  out  1  to Decode and IF/ID; discards wrong-path instructions.
- `stall_cycles`  out  CNT_W  cycles with `stall`=1 or freeze active.
- `flush_events`  out  CNT_W  number of taken branches accepted.

## Operation
- FSM states: RUN, LOAD_STALL, FLUSH. Counter `cnt` is 3 bits.
- Hazard terms:
  - `lu` = `ex_memread` & (`ex_rd`≠0) & (`ex_rd`==`id_rs1` | `ex_rd`==`id_rs2`).
  - `freeze` = `dmem_busy`.
- Priority, evaluated every cycle: `rst` > `freeze` > `branch_taken` > `lu`.
- **freeze** (overlays any state):
  - All four enables are 0; `stall`=0; `flush`=0.
  - State, `cnt` and `flush_events` hold.
  - `stall_cycles` increments.
  - `branch_taken` and `lu` are ignored. Both re-evaluate after the freeze, because EX is held.
- **RUN, `branch_taken`**:
  - `flush`=1, `pc_write`=1, `ifid_write`=1, `idex_write`=1, `exmem_write`=1, `stall`=0.
  - `flush_events` increments.
  - If FLUSH_CYCLES>1: go to FLUSH with `cnt`=FLUSH_CYCLES-1.
- **RUN, `lu`, no branch**:
  - `stall`=1, `pc_write`=0, `ifid_write`=0, `idex_write`=1 (bubble enters ID/EX), `exmem_write`=1.
  - `stall_cycles` increments.
  - If LOAD_USE_CYCLES>1: go to LOAD_STALL with `cnt`=LOAD_USE_CYCLES-1.
- **RUN, no event**: all enables 1; `stall`=0; `flush`=0.
- **LOAD_STALL**:
  - Outputs are the same as RUN+`lu`.
  - `cnt` decrements; return to RUN when `cnt`==1 on the same edge.
  - `branch_taken` here aborts the stall: RUN+`branch_taken` outputs apply, and the next state is FLUSH or RUN as above.
- **FLUSH**:
  - Outputs `flush`=1 and all enables 1.
  - `cnt` decrements; return to RUN when `cnt`==1.
  - `lu` and `branch_taken` are ignored, since only wrong-path or bubble instructions are present.
- Counters wrap modulo 2^CNT_W. No saturation.

## Timing
- `stall`, `flush` and the enables are Mealy outputs, combinational in the event cycle N. Decode therefore bubbles in the same cycle the hazard is seen.
- Extended bubbles and flushes cover cycles N+1 .. N+k-1, where k = LOAD_USE_CYCLES or FLUSH_CYCLES. Total asserted cycles are exactly k.
- FSM state, `cnt` and the counters are registered. Counter values are visible the cycle after the event.
- Reset:
  - While `rst`=1: all enables 0, `stall`=0, `flush`=0.
  - At the edge: state←RUN, `cnt`←0, both counters←0.
  - Reset mid-stall or mid-flush abandons the sequence.
- First cycle after reset release: RUN. Outputs follow inputs.
- `freeze` arriving mid-sequence does not consume a counted cycle. The sequence resumes with the same `cnt` on the first cycle with `dmem_busy`=0.

## Structure
- Shared package `rv32i_ctrl_pkg`:
  - Enum `hz_state_t` {RUN, LOAD_STALL, FLUSH}.
  - Constant `REG_ZERO`=5'd0.
  - Opcode localparams already used by the decode logic.
- One sub-module `hazard_perf_cnt`. It is a CNT_W counter with a synchronous clear and an increment enable, instantiated twice.
- FSM, hazard terms and output mux live in `hazard_ctrl`.

## Test plan
- Load-use, defaults:
  - Stimulus: `ex_memread`=1, `ex_rd`=5, `id_rs2`=5 for one cycle.
  - Required: `stall`=1, `pc_write`=0, `ifid_write`=0 for exactly 1 cycle; `stall_cycles`=1.
  - Repeat with `ex_rd`=0: no stall.
- Branch with FLUSH_CYCLES=2:
  - Stimulus: `branch_taken`=1 for one cycle.
  - Required: `flush`=1 for 2 cycles; `pc_write`=1 throughout; `flush_events`=1.
- Simultaneous `branch_taken` and `lu`:
  - Required: `flush`=1, `stall`=0, `stall_cycles` unchanged.
- `dmem_busy` high for 3 cycles during LOAD_STALL with LOAD_USE_CYCLES=3, `cnt`=2:
  - Required: all enables 0 for 3 cycles, then 2 more stall cycles; `stall_cycles`=6 total.
- `rst` asserted in the second FLUSH cycle:
  - Required: next cycle in RUN; `flush`=0; counters 0; enables 1 once `rst` is released.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared control package for the RV32I 5-stage core.
// Holds the hazard-controller state type, the x0 register address and the
// major opcode values used by the decode logic.
package rv32i_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running performance counter with synchronous clear and increment enable.
// Wraps modulo 2^CntW.
// Ports:
//   clk_i  clock, rising edge
//   clr_i  synchronous clear (wins over inc_i)
//   inc_i  add one this cycle
//   cnt_o  current count
module hazard_perf_cnt #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the RV32I 5-stage core.
// Sequences load-use bubbles, taken-branch flushes and data-memory freezes,
// and keeps stall/flush performance counters.
// Ports:
//   clk, rst (sync, active-high)
//   id_rs1, id_rs2      source registers leaving Decode
//   ex_rd, ex_memread   destination / load flag of the EX instruction
//   branch_taken        EX resolved a taken control transfer
//   dmem_busy           data memory stalls the whole pipe
//   pc_write, ifid_write, idex_write, exmem_write  pipeline register enables
//   stall, flush        Decode control
//   stall_cycles, flush_events  performance counters
module hazard_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES    = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  hz_state_t  state_d, state_q;
  logic [2:0] cnt_d, cnt_q;
  logic       lu;
  logic       stall_inc, flush_inc;

  assign lu = ex_memread && (ex_rd != REG_ZERO) &&
              ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_d     = RUN;
      cnt_d       = 3'd0;
    end else if (dmem_busy) begin
      // Whole pipe holds; EX is frozen so branch/lu are re-seen afterwards.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      stall_inc   = 1'b1;
    end else begin
      unique case (state_q)
        RUN, LOAD_STALL: begin
          if (branch_taken) begin
            // Also aborts a pending load-use stall.
            flush     = 1'b1;
            flush_inc = 1'b1;
            state_d   = RUN;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = 3'(FLUSH_CYCLES - 1);
            end
          end else if (state_q == LOAD_STALL || lu) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_inc  = 1'b1;
            if (state_q == LOAD_STALL) begin
              cnt_d = cnt_q - 3'd1;
              if (cnt_q == 3'd1) state_d = RUN;
            end else if (LOAD_USE_CYCLES > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = 3'(LOAD_USE_CYCLES - 1);
            end
          end
        end
        FLUSH: begin
          flush = 1'b1;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  hazard_perf_cnt #(
    .CntW (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cycles)
  );

  hazard_perf_cnt #(
    .CntW (CNT_W)
  ) u_flush_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (flush_inc),
    .cnt_o (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share the stimulus:
// u_def uses default parameters, u_ext uses LOAD_USE_CYCLES=3, FLUSH_CYCLES=2.
// Outputs are packed as {pc_write, ifid_write, idex_write, exmem_write, stall, flush}.
module tb_hazard_ctrl;

  localparam logic [5:0] ONORM  = 6'b111100;
  localparam logic [5:0] OSTALL = 6'b001110;
  localparam logic [5:0] OFLUSH = 6'b111101;
  localparam logic [5:0] OHOLD  = 6'b000000;

  typedef struct {
    string       tag;
    int          which;
    logic [5:0]  outs;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_memread, branch_taken, dmem_busy;

  logic        pc0, ifid0, idex0, exmem0, stall0, flush0;
  logic        pc1, ifid1, idex1, exmem1, stall1, flush1;
  logic [31:0] sc0, fe0, sc1, fe1;

  always #5 clk = ~clk;

  hazard_ctrl u_def (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .branch_taken (branch_taken),
    .dmem_busy    (dmem_busy),
    .pc_write     (pc0),
    .ifid_write   (ifid0),
    .idex_write   (idex0),
    .exmem_write  (exmem0),
    .stall        (stall0),
    .flush        (flush0),
    .stall_cycles (sc0),
    .flush_events (fe0)
  );

  hazard_ctrl #(
    .LOAD_USE_CYCLES (3),
    .FLUSH_CYCLES    (2),
    .CNT_W           (32)
  ) u_ext (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .branch_taken (branch_taken),
    .dmem_busy    (dmem_busy),
    .pc_write     (pc1),
    .ifid_write   (ifid1),
    .idex_write   (idex1),
    .exmem_write  (exmem1),
    .stall        (stall1),
    .flush        (flush1),
    .stall_cycles (sc1),
    .flush_events (fe1)
  );

  task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic mr, input logic br, input logic busy, input logic r);
    id_rs1       = rs1;
    id_rs2       = rs2;
    ex_rd        = rd;
    ex_memread   = mr;
    branch_taken = br;
    dmem_busy    = busy;
    rst          = r;
  endtask

  task automatic exp(input int which, input string tag, input logic [5:0] outs,
                     input int sc, input int fe);
    exp_t e;
    e.tag   = tag;
    e.which = which;
    e.outs  = outs;
    e.sc    = sc;
    e.fe    = fe;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [5:0]  o;
    logic [31:0] s, f;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = (e.which == 0) ? {pc0, ifid0, idex0, exmem0, stall0, flush0}
                         : {pc1, ifid1, idex1, exmem1, stall1, flush1};
      s = (e.which == 0) ? sc0 : sc1;
      f = (e.which == 0) ? fe0 : fe1;
      n_assert++;
      assert (o === e.outs) else begin
        n_fail++;
        $error("FAIL %s/dut%0d outs: got %b required %b", e.tag, e.which, o, e.outs);
      end
      n_assert++;
      assert (s === e.sc) else begin
        n_fail++;
        $error("FAIL %s/dut%0d stall_cycles: got %0d required %0d", e.tag, e.which, s, e.sc);
      end
      n_assert++;
      assert (f === e.fe) else begin
        n_fail++;
        $error("FAIL %s/dut%0d flush_events: got %0d required %0d", e.tag, e.which, f, e.fe);
      end
    end
  endtask

  // Check mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    drv(0, 0, 0, 0, 0, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 1); exp(0, "rst", OHOLD, 0, 0); exp(1, "rst", OHOLD, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "run", ONORM, 0, 0); exp(1, "run", ONORM, 0, 0); tick();

    // Load-use on rs2
    drv(0, 5, 5, 1, 0, 0, 0); exp(0, "lu_rs2", OSTALL, 0, 0); exp(1, "lu_rs2", OSTALL, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "lu_rs2+1", ONORM, 1, 0); exp(1, "lu_rs2+1", OSTALL, 1, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "lu_rs2+2", ONORM, 1, 0); exp(1, "lu_rs2+2", OSTALL, 2, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "lu_rs2+3", ONORM, 1, 0); exp(1, "lu_rs2+3", ONORM, 3, 0); tick();

    // Load to x0, and a load whose rd matches neither source
    drv(0, 0, 0, 1, 0, 0, 0); exp(0, "lu_x0", ONORM, 1, 0); exp(1, "lu_x0", ONORM, 3, 0); tick();
    drv(3, 4, 7, 1, 0, 0, 0); exp(0, "lu_miss", ONORM, 1, 0); exp(1, "lu_miss", ONORM, 3, 0); tick();

    // Load-use on rs1
    drv(7, 3, 7, 1, 0, 0, 0); exp(0, "lu_rs1", OSTALL, 1, 0); exp(1, "lu_rs1", OSTALL, 3, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "lu_rs1+1", ONORM, 2, 0); exp(1, "lu_rs1+1", OSTALL, 4, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "lu_rs1+2", ONORM, 2, 0); exp(1, "lu_rs1+2", OSTALL, 5, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "lu_rs1+3", ONORM, 2, 0); exp(1, "lu_rs1+3", ONORM, 6, 0); tick();

    // Taken branch
    drv(0, 0, 0, 0, 1, 0, 0); exp(0, "br", OFLUSH, 2, 0); exp(1, "br", OFLUSH, 6, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "br+1", ONORM, 2, 1); exp(1, "br+1", OFLUSH, 6, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "br+2", ONORM, 2, 1); exp(1, "br+2", ONORM, 6, 1); tick();

    // Branch and load-use together: branch wins
    drv(0, 5, 5, 1, 1, 0, 0); exp(0, "br_lu", OFLUSH, 2, 1); exp(1, "br_lu", OFLUSH, 6, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "br_lu+1", ONORM, 2, 2); exp(1, "br_lu+1", OFLUSH, 6, 2); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "br_lu+2", ONORM, 2, 2); exp(1, "br_lu+2", ONORM, 6, 2); tick();

    // Fresh reset, then freeze in the middle of an extended load-use stall
    drv(0, 0, 0, 0, 0, 0, 1); exp(0, "rst2", OHOLD, 2, 2); exp(1, "rst2", OHOLD, 6, 2); tick();
    drv(0, 5, 5, 1, 0, 0, 0); exp(0, "fz_lu", OSTALL, 0, 0); exp(1, "fz_lu", OSTALL, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 1, 0); exp(0, "fz1", OHOLD, 1, 0); exp(1, "fz1", OHOLD, 1, 0); tick();
    drv(0, 0, 0, 0, 0, 1, 0); exp(0, "fz2", OHOLD, 2, 0); exp(1, "fz2", OHOLD, 2, 0); tick();
    drv(0, 0, 0, 0, 0, 1, 0); exp(0, "fz3", OHOLD, 3, 0); exp(1, "fz3", OHOLD, 3, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "fz+1", ONORM, 4, 0); exp(1, "fz+1", OSTALL, 4, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "fz+2", ONORM, 4, 0); exp(1, "fz+2", OSTALL, 5, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "fz+3", ONORM, 4, 0); exp(1, "fz+3", ONORM, 6, 0); tick();

    // Freeze masks a branch; the branch is taken once the freeze lifts
    drv(0, 0, 0, 0, 1, 1, 0); exp(0, "fz_br", OHOLD, 4, 0); exp(1, "fz_br", OHOLD, 6, 0); tick();
    drv(0, 0, 0, 0, 1, 0, 0); exp(0, "fz_br+1", OFLUSH, 5, 0); exp(1, "fz_br+1", OFLUSH, 7, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "fz_br+2", ONORM, 5, 1); exp(1, "fz_br+2", OFLUSH, 7, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "fz_br+3", ONORM, 5, 1); exp(1, "fz_br+3", ONORM, 7, 1); tick();

    // Branch aborts an extended load-use stall
    drv(0, 9, 9, 1, 0, 0, 0); exp(0, "ab_lu", OSTALL, 5, 1); exp(1, "ab_lu", OSTALL, 7, 1); tick();
    drv(0, 0, 0, 0, 1, 0, 0); exp(0, "ab_br", OFLUSH, 6, 1); exp(1, "ab_br", OFLUSH, 8, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "ab+1", ONORM, 6, 2); exp(1, "ab+1", OFLUSH, 8, 2); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "ab+2", ONORM, 6, 2); exp(1, "ab+2", ONORM, 8, 2); tick();

    // Reset in the second flush cycle abandons the flush
    drv(0, 0, 0, 0, 1, 0, 0); exp(0, "rf_br", OFLUSH, 6, 2); exp(1, "rf_br", OFLUSH, 8, 2); tick();
    drv(0, 0, 0, 0, 0, 0, 1); exp(0, "rf_rst", OHOLD, 6, 3); exp(1, "rf_rst", OHOLD, 8, 3); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "rf+1", ONORM, 0, 0); exp(1, "rf+1", ONORM, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); exp(0, "rf+2", ONORM, 0, 0); exp(1, "rf+2", ONORM, 0, 0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
